// File: rtl/sap_pkg.sv
// Shared constants, command encoding and helpers for the SAP-2 register bank.
package sap_pkg;

  localparam int SAP_WIDTH = 8;

  // Bit positions inside the packed flag register
  localparam int SAP_FLAG_Z = 0;
  localparam int SAP_FLAG_S = 1;
  localparam int SAP_FLAG_C = 2;
  localparam int SAP_FLAG_N = 3;

  // Decoded, mutually exclusive write-side operation for one edge
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_LOAD = 2'd1,
    CMD_INC  = 2'd2,
    CMD_DEC  = 2'd3
  } cmd_e;

  // Select width for n registers; never less than one bit so ports stay legal
  function automatic int sap_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/m_register_cell.sv
// One WIDTH-bit register with synchronous reset, load, increment and decrement.
// Exposes the value it will take on the next edge plus the wrap/borrow carry,
// so the bank can derive its flags from the same arithmetic.
module m_register_cell
  import sap_pkg::*;
#(
  parameter int WIDTH = SAP_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_next,
  output logic             o_carry
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_carry;

  // Next value and carry; load has priority, the bank never asserts inc and dec together
  always_comb begin
    w_next  = r_q;
    w_carry = 1'b0;
    if (i_load) begin
      w_next = i_data;
    end else if (i_inc) begin
      w_next  = r_q + 1'b1;
      w_carry = (r_q == '1);
    end else if (i_dec) begin
      w_next  = r_q - 1'b1;
      w_carry = (r_q == '0);
    end
  end

  // Storage element
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_q <= '0;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q     = r_q;
  assign o_next  = w_next;
  assign o_carry = w_carry;

endmodule

// File: rtl/m_gp_register_bank.sv
// SAP-2 general-purpose register bank: DEPTH cells with write decode,
// tri-state W-bus read port, registered Z/S/C flags and an error pulse.
module m_gp_register_bank
  import sap_pkg::*;
#(
  parameter int WIDTH = SAP_WIDTH,
  parameter int DEPTH = 2,
  parameter int SEL_W = sap_clog2(DEPTH)
) (
  input  logic                   inCLK,
  input  logic                   inReset,
  input  logic [WIDTH-1:0]       inData,
  input  logic [SEL_W-1:0]       inWriteSel,
  input  logic                   inLoad,
  input  logic                   inInc,
  input  logic                   inDec,
  input  logic [SEL_W-1:0]       inReadSel,
  input  logic                   inEnableOut,
  output wire  [WIDTH-1:0]       outData,
  output logic [DEPTH*WIDTH-1:0] outMemory,
  output logic                   outZero,
  output logic                   outSign,
  output logic                   outCarry,
  output logic                   outError
);

  // One extra bit so the range check also works when DEPTH is a power of two
  localparam logic [SEL_W:0] LP_DEPTH = DEPTH[SEL_W:0];

  logic [WIDTH-1:0]     w_q     [DEPTH];
  logic [WIDTH-1:0]     w_next  [DEPTH];
  logic [DEPTH-1:0]     w_carry;
  logic [DEPTH-1:0]     w_hit;
  logic                 w_wr_valid;
  logic                 w_rd_valid;
  logic                 w_illegal;
  cmd_e                 w_cmd;
  logic [WIDTH-1:0]     w_sel_next;
  logic                 w_sel_carry;
  logic [WIDTH-1:0]     w_rd_data;
  logic                 w_out_en;
  logic [SAP_FLAG_N-1:0] r_flags;
  logic                 r_error;

  assign w_wr_valid = ({1'b0, inWriteSel} < LP_DEPTH);
  assign w_rd_valid = ({1'b0, inReadSel} < LP_DEPTH);

  // Priority decode: load beats inc/dec; simultaneous inc+dec or a bad target does nothing
  always_comb begin
    w_cmd = CMD_NONE;
    if (w_wr_valid) begin
      if (inLoad) begin
        w_cmd = CMD_LOAD;
      end else if (inInc && !inDec) begin
        w_cmd = CMD_INC;
      end else if (inDec && !inInc) begin
        w_cmd = CMD_DEC;
      end
    end
  end

  // Any command that is out of range or carries conflicting strobes is flagged
  always_comb begin
    w_illegal = 1'b0;
    if (inLoad || inInc || inDec) begin
      w_illegal = !w_wr_valid || (inLoad && (inInc || inDec)) || (inInc && inDec);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cell
      assign w_hit[gi] = (inWriteSel == SEL_W'(gi));

      m_register_cell #(
        .WIDTH (WIDTH)
      ) u_cell (
        .i_clk   (inCLK),
        .i_srst  (inReset),
        .i_load  (w_hit[gi] && (w_cmd == CMD_LOAD)),
        .i_inc   (w_hit[gi] && (w_cmd == CMD_INC)),
        .i_dec   (w_hit[gi] && (w_cmd == CMD_DEC)),
        .i_data  (inData),
        .o_q     (w_q[gi]),
        .o_next  (w_next[gi]),
        .o_carry (w_carry[gi])
      );

      assign outMemory[gi*WIDTH +: WIDTH] = w_q[gi];
    end
  endgenerate

  // Result of the targeted cell, used only when a command actually executes
  always_comb begin
    w_sel_next  = '0;
    w_sel_carry = 1'b0;
    if (w_wr_valid) begin
      w_sel_next  = w_next[inWriteSel];
      w_sel_carry = w_carry[inWriteSel];
    end
  end

  // Flags follow the register they describe on the same edge; hold otherwise
  always_ff @(posedge inCLK) begin
    if (inReset) begin
      r_flags             <= '0;
      r_flags[SAP_FLAG_Z] <= 1'b1;
    end else if (w_cmd != CMD_NONE) begin
      r_flags[SAP_FLAG_Z] <= (w_sel_next == '0);
      r_flags[SAP_FLAG_S] <= w_sel_next[WIDTH-1];
      r_flags[SAP_FLAG_C] <= w_sel_carry;
    end
  end

  // Error is a registered copy of the illegal-command strobe; reset masks it
  always_ff @(posedge inCLK) begin
    if (inReset) begin
      r_error <= 1'b0;
    end else begin
      r_error <= w_illegal;
    end
  end

  assign outZero  = r_flags[SAP_FLAG_Z];
  assign outSign  = r_flags[SAP_FLAG_S];
  assign outCarry = r_flags[SAP_FLAG_C];
  assign outError = r_error;

  // Combinational read mux; an out-of-range select releases the bus
  always_comb begin
    w_rd_data = '0;
    if (w_rd_valid) begin
      w_rd_data = w_q[inReadSel];
    end
  end

  assign w_out_en = inEnableOut && w_rd_valid;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bus
      bufif1 u_buf (outData[gi], w_rd_data[gi], w_out_en);
    end
  endgenerate

endmodule
